// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: one write port, two read ports,
// plus the busy flag raised during the post-reset clear sweep.
interface regfile_mp_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] wadr;
  logic [DATA_WIDTH-1:0] din;
  logic                  re;
  logic [ADDR_WIDTH-1:0] radr_a;
  logic [ADDR_WIDTH-1:0] radr_b;
  logic [DATA_WIDTH-1:0] dout_a;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  busy;

  modport master (
    output we, wadr, din, re, radr_a, radr_b,
    input  dout_a, dout_b, busy
  );

  modport slave (
    input  we, wadr, din, re, radr_a, radr_b,
    output dout_a, dout_b, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Register file with one write port, two registered read ports with write-through
// bypass, optional hard-zero register 0, and a clear sweep after every reset.
module regfile_mp #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ZERO_REG   = 0
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] dout_a_p1;
  logic [DATA_WIDTH-1:0] dout_b_p1;
  logic                  wr_en;
  logic                  rd_en;

  // Read value for one port: hard zero first, then same-cycle write bypass.
  function automatic logic [DATA_WIDTH-1:0] rd_sel(input logic [ADDR_WIDTH-1:0] adr);
    if ((ZERO_REG != 0) && (adr == '0))
      return '0;
    else if (wr_en && (bus.wadr == adr))
      return bus.din;
    else
      return regs[adr];
  endfunction

  always_comb begin
    state_nxt = state;
    if ((state == CLEAR) && (clr_cnt == LAST_ADR))
      state_nxt = RUN;
  end

  assign wr_en = (state == RUN) && bus.we && !((ZERO_REG != 0) && (bus.wadr == '0));
  assign rd_en = (state == RUN) && bus.re;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR)
        clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Storage: sweep writes zeros; reset cycles drop any pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        regs[clr_cnt] <= '0;
      else if (wr_en)
        regs[bus.wadr] <= bus.din;
    end
  end

  // Stage p1: registered read ports, held while re is low or during the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_a_p1 <= '0;
      dout_b_p1 <= '0;
    end else if (rd_en) begin
      dout_a_p1 <= rd_sel(bus.radr_a);
      dout_b_p1 <= rd_sel(bus.radr_b);
    end
  end

  assign bus.dout_a = dout_a_p1;
  assign bus.dout_b = dout_b_p1;
  assign bus.busy   = (state == CLEAR);
endmodule
